cp_insert_framer: RTL and testbench
===================================

CP_INSERT_FRAMER -- requirements
Module: cp_insert_framer

Interface
REQ-001 SHALL have parameter IN_DW, default 32, sample width (IQ packed).
REQ-002 SHALL have parameter FFT_LEN, default 256, samples per symbol body.
REQ-003 SHALL have parameters CP1_LEN, default 20, and CP2_LEN, default 18: long and short cyclic-prefix lengths.
REQ-004 SHALL have parameters SYM_PER_SF, default 14, and SF_MAX, default 20: symbols per subframe and subframes per SSB period.
REQ-005 SHALL have parameter SSB_SYM, default 2, symbol index (in subframe 0) carrying the SSB start.
REQ-006 SHALL have ports:
- clk_i  in  1  single clock.
- reset_ni  in  1  reset, asynchronous, active-low.
- s_axis_in_tdata  in  IN_DW  IFFT output sample.
- s_axis_in_tvalid  in  1  input valid.
- s_axis_in_tlast  in  1  last sample of symbol body.
- s_axis_in_tready  out  1  input ready.
- m_axis_out_tdata  out  IN_DW  sample with CP.
- m_axis_out_tvalid  out  1  output valid.
- m_axis_out_tready  in  1  downstream ready.
- symbol_start_o  out  1  high while first CP sample of a symbol is on m_axis_out_tdata.
- SSB_start_o  out  1  as symbol_start_o, only for SSB symbol.
- CP_len_o  out  $clog2(CP1_LEN+1)  CP length of symbol being output.
- sym_idx_o  out  $clog2(SYM_PER_SF)  symbol index in subframe.
- sf_idx_o  out  $clog2(SF_MAX)  subframe index.
- tlast_err_o  out  1  sticky tlast-mismatch flag.

Function
REQ-007 SHALL buffer input in two FFT_LEN-deep banks (ping-pong); write bank fills at addresses 0..FFT_LEN-1 in order.
REQ-008 SHALL accept a sample on s_axis_in_tvalid && s_axis_in_tready; tready high iff current write bank not full.
REQ-009 SHALL mark write bank full and toggle write bank on acceptance of its FFT_LEN-th sample, regardless of tlast.
REQ-010 SHALL set tlast_err_o when tlast is high on a sample other than the FFT_LEN-th, or low on the FFT_LEN-th; cleared only by reset.
REQ-011 SHALL output, per full read bank, CP_len samples from addresses FFT_LEN-CP_len..FFT_LEN-1, then FFT_LEN samples from 0..FFT_LEN-1.
REQ-012 SHALL use CP_len = CP1_LEN when sym_idx is 0 or 7, else CP2_LEN.
REQ-013 SHALL obey AXI-stream: once m_axis_out_tvalid is high, tdata and sidebands hold until m_axis_out_tready; tvalid never drops before handshake.
REQ-014 SHALL assert m_axis_out_tvalid with first CP sample on the 2nd rising edge after the edge accepting the FFT_LEN-th sample, when read side idle and m_axis_out_tready high.
REQ-015 SHALL produce no bubbles with m_axis_out_tready held high: FFT_LEN+CP_len consecutive valid cycles per symbol, back-to-back with next symbol when its bank is already full.
REQ-016 SHALL free read bank on handshake of its last sample; that bank may accept input from the next cycle.
REQ-017 SHALL hold CP_len_o, sym_idx_o, sf_idx_o constant across all samples of a symbol.
REQ-018 SHALL advance sym_idx after last sample of each symbol, wrapping SYM_PER_SF-1 -> 0; on wrap sf_idx increments, wrapping SF_MAX-1 -> 0.
REQ-019 SHALL assert SSB_start_o exactly when symbol_start_o is high and sf_idx_o==0 and sym_idx_o==SSB_SYM.
REQ-020 SHALL tolerate input and output handshakes in the same cycle on different banks with no data loss.

Reset
REQ-021 SHALL, on reset_ni low, asynchronously clear: both banks empty, m_axis_out_tvalid, symbol_start_o, SSB_start_o, tlast_err_o, s_axis_in_tready, sym_idx_o, sf_idx_o, m_axis_out_tdata to 0; CP_len_o to CP1_LEN.
REQ-022 SHALL discard all buffered/partial symbols on reset mid-operation; s_axis_in_tready high from the first edge after reset release.

Verification
REQ-023 Single symbol, ramp 0..255, tready=1 -> 276 outputs: 236..255 then 0..255; CP_len_o=20, sym_idx_o=0, symbol_start_o on first only.
REQ-024 14 ramp symbols continuous -> CP lengths 20,18x6,20,18x6; sym_idx 0..13 then 0; no output gaps after first.
REQ-025 Random m_axis_out_tready 50% -> data identical to REQ-023 order; tdata stable while tvalid && !tready; s_axis_in_tready drops with both banks full.
REQ-026 280 symbols -> SSB_start_o exactly once, at sf_idx 0, sym_idx 2; sf_idx wraps 19->0 after symbol 279.
REQ-027 tlast on sample 100 -> tlast_err_o=1 and stays; output still 276 samples per symbol.
REQ-028 Reset asserted mid-output sample 150 -> outputs cleared immediately; next symbol restarts at sym_idx 0 with CP_len 20.

Source files
------------

// File: rtl/cp_insert_framer.sv
// Cyclic-prefix insertion framer: ping-pong buffers IFFT symbol bodies and replays
// each one as CP tail + full body, tagging symbol/subframe position and SSB start.
module cp_insert_framer #(
    parameter int IN_DW      = 32,
    parameter int FFT_LEN    = 256,
    parameter int CP1_LEN    = 20,
    parameter int CP2_LEN    = 18,
    parameter int SYM_PER_SF = 14,
    parameter int SF_MAX     = 20,
    parameter int SSB_SYM    = 2
) (
    input  logic                            clk_i,
    input  logic                            reset_ni,
    input  logic [IN_DW-1:0]                s_axis_in_tdata,
    input  logic                            s_axis_in_tvalid,
    input  logic                            s_axis_in_tlast,
    output logic                            s_axis_in_tready,
    output logic [IN_DW-1:0]                m_axis_out_tdata,
    output logic                            m_axis_out_tvalid,
    input  logic                            m_axis_out_tready,
    output logic                            symbol_start_o,
    output logic                            SSB_start_o,
    output logic [$clog2(CP1_LEN+1)-1:0]    CP_len_o,
    output logic [$clog2(SYM_PER_SF)-1:0]   sym_idx_o,
    output logic [$clog2(SF_MAX)-1:0]       sf_idx_o,
    output logic                            tlast_err_o
);
    localparam int AW   = $clog2(FFT_LEN);
    localparam int CNTW = $clog2(FFT_LEN + CP1_LEN);
    localparam int LW   = $clog2(CP1_LEN + 1);
    localparam int SYMW = $clog2(SYM_PER_SF);
    localparam int SFW  = $clog2(SF_MAX);

    typedef enum logic {RD_IDLE, RD_RUN} rd_state_t;

    logic [IN_DW-1:0] mem [2][FFT_LEN];

    logic [1:0]      full_q, full_d;
    logic            wr_bank_q, wr_bank_d;
    logic [AW-1:0]   wr_addr_q;
    logic            in_acc, wr_last;

    rd_state_t       state_q, state_d;
    logic            rd_bank_q;
    logic [CNTW-1:0] cnt_q, last_cnt, rd_off;
    logic [AW-1:0]   rd_addr;
    logic [LW-1:0]   cur_cp;
    logic [SYMW-1:0] sym_q;
    logic [SFW-1:0]  sf_q;
    logic            out_last_q, out_bank_q;
    logic            load, load_last, out_hs_last;

    assign in_acc  = s_axis_in_tvalid && s_axis_in_tready;
    assign wr_last = (wr_addr_q == AW'(FFT_LEN - 1));

    // A bank is released by the output handshake and claimed by the write side on its last sample.
    always_comb begin
        full_d = full_q;
        if (out_hs_last)
            full_d[out_bank_q] = 1'b0;
        if (in_acc && wr_last)
            full_d[wr_bank_q] = 1'b1;
        wr_bank_d = wr_bank_q ^ (in_acc && wr_last);
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            full_q           <= '0;
            wr_bank_q        <= 1'b0;
            wr_addr_q        <= '0;
            s_axis_in_tready <= 1'b0;
            tlast_err_o      <= 1'b0;
        end else begin
            full_q           <= full_d;
            wr_bank_q        <= wr_bank_d;
            s_axis_in_tready <= !full_d[wr_bank_d];
            if (in_acc) begin
                wr_addr_q <= wr_last ? '0 : wr_addr_q + 1'b1;
                if (s_axis_in_tlast != wr_last)
                    tlast_err_o <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (in_acc)
            mem[wr_bank_q][wr_addr_q] <= s_axis_in_tdata;
    end

    // Read address walks the CP tail first, then the whole body.
    always_comb begin
        cur_cp   = (sym_q == '0 || sym_q == SYMW'(7)) ? LW'(CP1_LEN) : LW'(CP2_LEN);
        last_cnt = CNTW'(FFT_LEN) + CNTW'(cur_cp) - CNTW'(1);
        rd_off   = (cnt_q < CNTW'(cur_cp)) ? cnt_q + CNTW'(FFT_LEN) - CNTW'(cur_cp)
                                           : cnt_q - CNTW'(cur_cp);
        rd_addr  = rd_off[AW-1:0];
    end

    assign load        = (state_q == RD_RUN) && (!m_axis_out_tvalid || m_axis_out_tready);
    assign load_last   = load && (cnt_q == last_cnt);
    assign out_hs_last = m_axis_out_tvalid && m_axis_out_tready && out_last_q;

    // IDLE costs one cycle before the first fetch; RUN chains straight into an already-full bank.
    always_comb begin
        state_d = state_q;
        case (state_q)
            RD_IDLE: if (full_q[rd_bank_q]) state_d = RD_RUN;
            RD_RUN:  if (load_last && !full_q[!rd_bank_q]) state_d = RD_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q           <= RD_IDLE;
            rd_bank_q         <= 1'b0;
            cnt_q             <= '0;
            sym_q             <= '0;
            sf_q              <= '0;
            out_last_q        <= 1'b0;
            out_bank_q        <= 1'b0;
            m_axis_out_tvalid <= 1'b0;
            m_axis_out_tdata  <= '0;
            symbol_start_o    <= 1'b0;
            SSB_start_o       <= 1'b0;
            CP_len_o          <= LW'(CP1_LEN);
            sym_idx_o         <= '0;
            sf_idx_o          <= '0;
        end else begin
            state_q <= state_d;
            if (load) begin
                m_axis_out_tdata  <= mem[rd_bank_q][rd_addr];
                m_axis_out_tvalid <= 1'b1;
                out_last_q        <= load_last;
                out_bank_q        <= rd_bank_q;
                symbol_start_o    <= (cnt_q == '0);
                SSB_start_o       <= (cnt_q == '0) && (sf_q == '0) && (sym_q == SYMW'(SSB_SYM));
                if (cnt_q == '0) begin
                    CP_len_o  <= cur_cp;
                    sym_idx_o <= sym_q;
                    sf_idx_o  <= sf_q;
                end
                if (load_last) begin
                    cnt_q     <= '0;
                    rd_bank_q <= !rd_bank_q;
                    if (sym_q == SYMW'(SYM_PER_SF - 1)) begin
                        sym_q <= '0;
                        sf_q  <= (sf_q == SFW'(SF_MAX - 1)) ? '0 : sf_q + 1'b1;
                    end else begin
                        sym_q <= sym_q + 1'b1;
                    end
                end else begin
                    cnt_q <= cnt_q + 1'b1;
                end
            end else if (m_axis_out_tready) begin
                m_axis_out_tvalid <= 1'b0;
                symbol_start_o    <= 1'b0;
                SSB_start_o       <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_cp_insert_framer.sv
// Bench for cp_insert_framer: random/ramp symbols scored against a queue of
// expected CP-framed samples built from the symbol numbering rules.
module tb_cp_insert_framer;
    localparam int FFT  = 256;
    localparam int CP1  = 20;
    localparam int CP2  = 18;
    localparam int SPS  = 14;
    localparam int SFM  = 20;
    localparam int SSBS = 2;

    logic        clk_i = 1'b0;
    logic        reset_ni;
    logic [31:0] s_tdata;
    logic        s_tvalid, s_tlast, s_tready;
    logic [31:0] m_tdata;
    logic        m_tvalid, m_tready;
    logic        sop, ssb, tlast_err;
    logic [4:0]  cp_len;
    logic [3:0]  sym_idx;
    logic [4:0]  sf_idx;

    cp_insert_framer dut (
        .clk_i(clk_i), .reset_ni(reset_ni),
        .s_axis_in_tdata(s_tdata), .s_axis_in_tvalid(s_tvalid),
        .s_axis_in_tlast(s_tlast), .s_axis_in_tready(s_tready),
        .m_axis_out_tdata(m_tdata), .m_axis_out_tvalid(m_tvalid),
        .m_axis_out_tready(m_tready),
        .symbol_start_o(sop), .SSB_start_o(ssb), .CP_len_o(cp_len),
        .sym_idx_o(sym_idx), .sf_idx_o(sf_idx), .tlast_err_o(tlast_err)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [31:0] d;
        int          cp;
        int          sym;
        int          sf;
        bit          sop;
        bit          ssb;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] sym_buf [FFT];
    int n_chk = 0, n_err = 0;
    int sym_k = 0, cyc = 0, hs_cnt = 0, ssb_cnt = 0, gaps = 0;
    int last_acc = 0, lat = -1;
    bit prev_stall = 0, prev_vld = 0, gap_arm = 0, gap_en = 0, rand_rdy = 0, mon_en = 0;
    logic [31:0] prev_data = '0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] expv);
        n_chk++;
        if (got !== expv) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, expv, $time);
        end
    endtask

    // Expected stream for one symbol: CP tail copy then full body, tagged by global symbol number.
    task automatic push_sym();
        int sym = sym_k % SPS;
        int sf  = (sym_k / SPS) % SFM;
        int cp  = (sym == 0 || sym == 7) ? CP1 : CP2;
        for (int i = 0; i < cp + FFT; i++) begin
            exp_t e;
            e.d   = (i < cp) ? sym_buf[FFT - cp + i] : sym_buf[i - cp];
            e.cp  = cp;
            e.sym = sym;
            e.sf  = sf;
            e.sop = (i == 0);
            e.ssb = (i == 0) && (sf == 0) && (sym == SSBS);
            exp_q.push_back(e);
        end
        sym_k++;
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
        if (rand_rdy) m_tready = 1'($urandom_range(0, 1));
    endtask

    task automatic send_sym(input bit ramp, input int tl_pos);
        for (int i = 0; i < FFT; i++) begin
            int n = 0;
            sym_buf[i] = ramp ? 32'(i) : $urandom;
            s_tdata  = sym_buf[i];
            s_tlast  = (i == tl_pos);
            s_tvalid = 1'b1;
            forever begin
                @(negedge clk_i);
                if (s_tready) break;
                tick();
                n++;
                if (n > 5000) begin
                    chk("in_timeout", 32'd1, 32'd0);
                    s_tvalid = 1'b0;
                    return;
                end
            end
            tick();
        end
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        push_sym();
    endtask

    task automatic wait_drain(input int maxc);
        int n = 0;
        while (exp_q.size() != 0 && n < maxc) begin
            tick();
            n++;
        end
        chk("drain_left", 32'(exp_q.size()), 32'd0);
    endtask

    initial forever begin
        @(posedge clk_i);
        cyc++;
    end

    // Output monitor: scoreboard, AXI hold rule, gap counter and first-output latency.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk_i);
            if (mon_en && reset_ni) begin
                if (s_tvalid && s_tready) last_acc = cyc + 1;
                if (m_tvalid && !prev_vld) lat = cyc - last_acc;
                if (prev_stall) begin
                    chk("hold_vld", 32'(m_tvalid), 32'd1);
                    chk("hold_data", m_tdata, prev_data);
                end
                if (gap_arm && m_tvalid) gap_en = 1'b1;
                if (gap_en && !m_tvalid && exp_q.size() != 0) gaps++;
                if (m_tvalid && m_tready) begin
                    hs_cnt++;
                    ssb_cnt += int'(ssb);
                    if (exp_q.size() == 0) begin
                        chk("unexp_out", 32'd1, 32'd0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("data", m_tdata, e.d);
                        chk("cp_len", 32'(cp_len), 32'(e.cp));
                        chk("sym_idx", 32'(sym_idx), 32'(e.sym));
                        chk("sf_idx", 32'(sf_idx), 32'(e.sf));
                        chk("sym_start", 32'(sop), 32'(e.sop));
                        chk("ssb_start", 32'(ssb), 32'(e.ssb));
                    end
                end
                prev_stall = m_tvalid && !m_tready;
                prev_vld   = m_tvalid;
                prev_data  = m_tdata;
            end
        end
    end

    initial begin
        int base, n;
        s_tvalid = 1'b0; s_tlast = 1'b0; s_tdata = '0; m_tready = 1'b1; reset_ni = 1'b0;
        #12;
        chk("rst_vld", 32'(m_tvalid), 32'd0);
        chk("rst_srdy", 32'(s_tready), 32'd0);
        chk("rst_cp", 32'(cp_len), 32'(CP1));
        chk("rst_sym", 32'(sym_idx), 32'd0);
        chk("rst_sf", 32'(sf_idx), 32'd0);
        chk("rst_terr", 32'(tlast_err), 32'd0);
        chk("rst_data", m_tdata, 32'd0);
        chk("rst_sop", 32'(sop), 32'd0);
        @(negedge clk_i);
        reset_ni = 1'b1;
        mon_en   = 1'b1;
        tick();
        chk("srdy_after_rst", 32'(s_tready), 32'd1);

        // single ramp symbol, idle read side
        send_sym(1'b1, FFT - 1);
        wait_drain(2000);
        chk("first_latency", 32'(lat), 32'd2);
        chk("terr_clean", 32'(tlast_err), 32'd0);

        // continuous stream up to 280 symbols, tlast fault on one symbol
        gap_arm = 1'b1;
        for (int k = 1; k < 280; k++) begin
            send_sym(k < 14, (k == 21) ? 100 : FFT - 1);
            if (k == 21) chk("terr_set", 32'(tlast_err), 32'd1);
        end
        wait_drain(2000);
        gap_arm = 1'b0;
        gap_en  = 1'b0;
        chk("no_gaps", 32'(gaps), 32'd0);
        chk("ssb_once", 32'(ssb_cnt), 32'd1);
        chk("hs_total", 32'(hs_cnt), 32'(SFM * (2 * (FFT + CP1) + 12 * (FFT + CP2))));

        // backpressure: both banks fill, then random ready drains
        m_tready = 1'b0;
        send_sym(1'b0, FFT - 1);
        send_sym(1'b0, FFT - 1);
        repeat (5) tick();
        chk("in_stall", 32'(s_tready), 32'd0);
        chk("out_stuck_vld", 32'(m_tvalid), 32'd1);
        rand_rdy = 1'b1;
        send_sym(1'b0, FFT - 1);
        wait_drain(5000);
        rand_rdy = 1'b0;
        m_tready = 1'b1;
        chk("terr_sticky", 32'(tlast_err), 32'd1);

        // reset in the middle of a symbol's output
        send_sym(1'b1, FFT - 1);
        base = hs_cnt;
        n = 0;
        while (hs_cnt - base < 150 && n < 2000) begin
            @(negedge clk_i);
            n++;
        end
        chk("mid_reached", 32'(hs_cnt - base >= 150), 32'd1);
        #2;
        reset_ni = 1'b0;
        #1;
        chk("rst2_vld", 32'(m_tvalid), 32'd0);
        chk("rst2_data", m_tdata, 32'd0);
        chk("rst2_sop", 32'(sop), 32'd0);
        chk("rst2_terr", 32'(tlast_err), 32'd0);
        chk("rst2_cp", 32'(cp_len), 32'(CP1));
        chk("rst2_sym", 32'(sym_idx), 32'd0);
        chk("rst2_srdy", 32'(s_tready), 32'd0);
        exp_q.delete();
        sym_k = 0;
        prev_stall = 1'b0;
        prev_vld = 1'b0;
        repeat (2) @(negedge clk_i);
        reset_ni = 1'b1;
        tick();
        chk("srdy_rst2", 32'(s_tready), 32'd1);
        send_sym(1'b1, FFT - 1);
        wait_drain(2000);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
